axi4_lite_slave_mem: RTL and testbench

Synthesisable AXI4-Lite slave with byte-strobed on-chip memory, parametrised in address/data width, memory size and base address. It adds programmable per-channel wait-state insertion and address/protection-based error responses. It sits behind the slave agent as the DUT-side responder and serves as the golden memory model for master-side tests. Write and read channels run independent FSMs, each with one transaction outstanding.

---
 rtl/axi4_lite_slave_mem_pkg.sv | 44 ++++
 rtl/axi4_lite_slave_mem_wait_counter.sv | 31 +++
 rtl/axi4_lite_slave_mem.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4_lite_slave_mem.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared AXI4-Lite types for the slave memory: response codes, the per-channel
// FSM state encodings and the address/protection decode rule.
package axi4_lite_slave_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_lite_resp_e;

  typedef axi4_lite_resp_e bresp_e;
  typedef axi4_lite_resp_e rresp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } axi4_lite_wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } axi4_lite_rd_state_e;

  // Response code for an access. The offset is taken in 64 bits so an address
  // below base wraps to a huge value and falls out of range with one compare.
  function automatic axi4_lite_resp_e axi4_lite_decode(
    input logic [63:0] addr,
    input logic [2:0]  prot,
    input logic [63:0] base,
    input logic [63:0] size,
    input logic        secure_only
  );
    logic [63:0] offset;
    offset = addr - base;
    if (offset >= size) return RESP_DECERR;
    // prot[1] set marks a non-secure access
    if (secure_only && ((prot & 3'b010) != 3'b000)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_mem_wait_counter.sv
// Loadable down-counter used to insert wait states on one channel. The zero
// flag is combinational from the count so the owning FSM can act on it in
// the same cycle the count reaches zero.
module axi4_lite_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_count;

  // Load takes priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WAIT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-strobed on-chip memory. Write and read
// channels each run their own FSM with one transaction outstanding and a
// programmable number of wait states before the response. Out-of-range
// accesses return DECERR; with SECURE_ONLY set, non-secure accesses return
// SLVERR. Neither error updates memory, and error reads return zero data.
// DATA_WIDTH is expected to be 32 or 64; MEM_BYTES a power of two and a
// multiple of the bus width; BASE_ADDR aligned to MEM_BYTES.
module axi4_lite_slave_mem
  import axi4_lite_slave_mem_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       MEM_BYTES     = 4096,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_W        = 4,
  parameter bit                       SECURE_ONLY   = 1'b0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [WAIT_W-1:0]         write_wait_cycles,
  input  logic [WAIT_W-1:0]         read_wait_cycles
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int WORDS    = MEM_BYTES / STRB_W;
  localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  // ---------------------------------------------------------- write channel
  axi4_lite_wr_state_e      r_wr_state;
  logic                     r_aw_held;
  logic                     r_w_held;
  logic [ADDRESS_WIDTH-1:0] r_awaddr;
  logic [2:0]               r_awprot;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [STRB_W-1:0]        r_wstrb;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_bvalid;
  bresp_e                   r_bresp;

  logic                     w_aw_fire;
  logic                     w_w_fire;
  logic                     w_aw_have;
  logic                     w_w_have;
  logic                     w_wr_start;
  logic                     w_wr_zero;
  logic                     w_mem_we;
  bresp_e                   w_wr_resp;
  logic [ADDRESS_WIDTH-1:0] w_wr_offset;
  logic [IDX_W-1:0]         w_wr_idx;

  assign w_aw_fire  = awvalid & r_awready;
  assign w_w_fire   = wvalid & r_wready;
  assign w_aw_have  = r_aw_held | w_aw_fire;
  assign w_w_have   = r_w_held | w_w_fire;
  // Readies are only high in W_IDLE, so a completed pair implies W_IDLE.
  assign w_wr_start = (r_wr_state == W_IDLE) & w_aw_have & w_w_have;

  assign w_wr_resp   = axi4_lite_decode(64'(r_awaddr), r_awprot, 64'(BASE_ADDR),
                                        64'(MEM_BYTES), SECURE_ONLY);
  assign w_wr_offset = r_awaddr - BASE_ADDR;
  assign w_wr_idx    = IDX_W'(w_wr_offset >> ADDR_LSB);
  assign w_mem_we    = (r_wr_state == W_WAIT) & w_wr_zero & (w_wr_resp == RESP_OKAY);

  axi4_lite_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wr_wait (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_load     (w_wr_start),
    .i_load_val (write_wait_cycles),
    .i_dec      (r_wr_state == W_WAIT),
    .o_zero     (w_wr_zero)
  );

  // Write FSM: collect AW and W in any order, wait, commit, then hold B.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_awprot   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_awaddr <= awaddr;
            r_awprot <= awprot;
          end
          if (w_w_fire) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
          end
          if (w_wr_start) begin
            r_wr_state <= W_WAIT;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
          end else begin
            // Also raises the readies on the first edge out of reset.
            r_aw_held <= w_aw_have;
            r_w_held  <= w_w_have;
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
          end
        end
        W_WAIT: begin
          if (w_wr_zero) begin
            r_wr_state <= W_RESP;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_wr_resp;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_wr_state <= W_IDLE;
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane memory update on the commit edge of an OKAY write.
  always_ff @(posedge aclk) begin
    // NOTE: the array has no reset so contents survive aresetn and it maps to RAM.
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------- read channel
  axi4_lite_rd_state_e      r_rd_state;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic [2:0]               r_arprot;
  logic                     r_arready;
  logic                     r_rvalid;
  rresp_e                   r_rresp;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic                     w_ar_fire;
  logic                     w_rd_zero;
  rresp_e                   w_rd_resp;
  logic [ADDRESS_WIDTH-1:0] w_rd_offset;
  logic [IDX_W-1:0]         w_rd_idx;

  assign w_ar_fire   = arvalid & r_arready;
  assign w_rd_resp   = axi4_lite_decode(64'(r_araddr), r_arprot, 64'(BASE_ADDR),
                                        64'(MEM_BYTES), SECURE_ONLY);
  assign w_rd_offset = r_araddr - BASE_ADDR;
  assign w_rd_idx    = IDX_W'(w_rd_offset >> ADDR_LSB);

  axi4_lite_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_rd_wait (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_load     (w_ar_fire),
    .i_load_val (read_wait_cycles),
    .i_dec      (r_rd_state == R_WAIT),
    .o_zero     (w_rd_zero)
  );

  // Read FSM: accept AR, wait, capture data (pre-write value on a same-edge
  // write), then hold R until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_araddr   <= '0;
      r_arprot   <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rd_state <= R_WAIT;
            r_araddr   <= araddr;
            r_arprot   <= arprot;
            r_arready  <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (w_rd_zero) begin
            r_rd_state <= R_RESP;
            r_rvalid   <= 1'b1;
            r_rresp    <= w_rd_resp;
            r_rdata    <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Scoreboard bench for axi4_lite_slave_mem: stimulus tasks push expected B/R
// responses (code, data, arrival cycle) computed from a byte-addressed model;
// a negedge monitor pops and compares whenever bvalid/rvalid rises, and checks
// that valid and payload hold until the handshake.
module tb_axi4_lite_slave_mem;

  localparam int          AW        = 32;
  localparam int          DW        = 32;
  localparam int          MEM_BYTES = 4096;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam bit          SECURE    = 1'b1;
  localparam int          BUDGET    = 300;

  logic          aclk;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [3:0]    write_wait_cycles;
  logic [3:0]    read_wait_cycles;

  axi4_lite_slave_mem #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .MEM_BYTES     (MEM_BYTES),
    .BASE_ADDR     (BASE),
    .WAIT_W        (4),
    .SECURE_ONLY   (SECURE)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .awaddr            (awaddr),
    .awprot            (awprot),
    .awvalid           (awvalid),
    .awready           (awready),
    .wdata             (wdata),
    .wstrb             (wstrb),
    .wvalid            (wvalid),
    .wready            (wready),
    .bresp             (bresp),
    .bvalid            (bvalid),
    .bready            (bready),
    .araddr            (araddr),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rdata             (rdata),
    .rresp             (rresp),
    .rvalid            (rvalid),
    .rready            (rready),
    .write_wait_cycles (write_wait_cycles),
    .read_wait_cycles  (read_wait_cycles)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t q_b[$];
  exp_t q_r[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [7:0] model_mem [logic [31:0]];
  bit   rand_bp     = 1'b0;
  bit   cfg_shuffle = 1'b0;
  logic bready_force;
  logic rready_force;

  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] prot);
    longint unsigned a;
    a = longint'(addr);
    if (a < longint'(BASE) || a >= longint'(BASE) + MEM_BYTES) return 2'b11;
    if (SECURE && prot[1]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] word_base;
    word_base = {addr[31:2], 2'b00};
    for (int lane = 0; lane < 4; lane++)
      if (strb[lane]) model_mem[word_base + 32'(lane)] = data[lane*8 +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] word_base;
    logic [31:0] d;
    word_base = {addr[31:2], 2'b00};
    d = '0;
    for (int lane = 0; lane < 4; lane++)
      if (model_mem.exists(word_base + 32'(lane))) d[lane*8 +: 8] = model_mem[word_base + 32'(lane)];
    return d;
  endfunction

  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    if (k == 7) return 32'h0000_0FFC;
    if (k == 8) return 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4;
    return 32'hFFFF_FFFC;
  endfunction

  // --------------------------------------------------------- ready driver
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (rand_bp) begin
        bready = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 3) != 0);
      end else begin
        bready = bready_force;
        rready = rready_force;
      end
    end
  end

  // -------------------------------------------------------------- monitor
  logic        b_prev_v, b_prev_r, r_prev_v, r_prev_r;
  logic [1:0]  b_hold_resp, r_hold_resp;
  logic [31:0] r_hold_data;
  exp_t        mon_e;

  always @(negedge aclk) begin
    if (!aresetn) begin
      b_prev_v = 1'b0; b_prev_r = 1'b0;
      r_prev_v = 1'b0; r_prev_r = 1'b0;
    end else begin
      if (b_prev_v && !b_prev_r) begin
        check("bvalid_hold", bvalid, 1'b1);
        check("bresp_stable", bresp, b_hold_resp);
      end else if (bvalid) begin
        if (q_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected: bvalid high at cycle %0d with no write outstanding", cyc);
        end else begin
          mon_e = q_b.pop_front();
          check("bresp", bresp, mon_e.resp);
          check("b_latency", cyc, mon_e.edge_no);
        end
        b_hold_resp = bresp;
      end
      if (r_prev_v && !r_prev_r) begin
        check("rvalid_hold", rvalid, 1'b1);
        check("rresp_stable", rresp, r_hold_resp);
        check("rdata_stable", rdata, r_hold_data);
      end else if (rvalid) begin
        if (q_r.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_unexpected: rvalid high at cycle %0d with no read outstanding", cyc);
        end else begin
          mon_e = q_r.pop_front();
          check("rresp", rresp, mon_e.resp);
          check("rdata", rdata, mon_e.data);
          check("r_latency", cyc, mon_e.edge_no);
        end
        r_hold_resp = rresp;
        r_hold_data = rdata;
      end
      b_prev_v = bvalid; b_prev_r = bready;
      r_prev_v = rvalid; r_prev_r = rready;
    end
  end

  // ------------------------------------------------------ channel drivers
  task automatic send_aw(input logic [31:0] addr, input logic [2:0] prot, output int hs);
    int n;
    n = 0;
    @(posedge aclk); #1;
    awaddr = addr; awprot = prot; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < BUDGET) begin @(negedge aclk); n++; end
    hs = cyc + 1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("aw_timeout", n >= BUDGET, 1'b0);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output int hs);
    int n;
    n = 0;
    @(posedge aclk); #1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    @(negedge aclk);
    while (!wready && n < BUDGET) begin @(negedge aclk); n++; end
    hs = cyc + 1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    check("w_timeout", n >= BUDGET, 1'b0);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [2:0] prot, output int hs);
    int n;
    n = 0;
    @(posedge aclk); #1;
    araddr = addr; arprot = prot; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < BUDGET) begin @(negedge aclk); n++; end
    hs = cyc + 1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("ar_timeout", n >= BUDGET, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int aw_delay, input int w_delay);
    int   aw_hs, w_hs, last;
    exp_t e;
    fork
      begin repeat (aw_delay) @(posedge aclk); send_aw(addr, prot, aw_hs); end
      begin repeat (w_delay) @(posedge aclk); send_w(data, strb, w_hs); end
    join
    last      = (aw_hs > w_hs) ? aw_hs : w_hs;
    e.resp    = model_resp(addr, prot);
    e.data    = '0;
    e.edge_no = last + 1 + int'(write_wait_cycles);
    q_b.push_back(e);
    if (e.resp == 2'b00) model_write(addr, data, strb);
    if (cfg_shuffle) write_wait_cycles = 4'($urandom_range(0, 15));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] ok_data);
    int   hs;
    exp_t e;
    send_ar(addr, prot, hs);
    e.resp    = model_resp(addr, prot);
    e.data    = (e.resp == 2'b00) ? ok_data : 32'h0;
    e.edge_no = hs + 1 + int'(read_wait_cycles);
    q_r.push_back(e);
    if (cfg_shuffle) read_wait_cycles = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge aclk);
    while ((q_b.size() != 0 || q_r.size() != 0 || bvalid || rvalid) && n < BUDGET) begin
      @(negedge aclk);
      n++;
    end
    check("idle_timeout", n >= BUDGET, 1'b0);
  endtask

  // --------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int          n;
    int          hs_a, hs_w;
    logic [31:0] old, a;
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    write_wait_cycles = '0; read_wait_cycles = '0;
    bready_force = 1'b1; rready_force = 1'b1;

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    aresetn = 1'b1;
    #1;
    check("pre_edge_awready", awready, 1'b0);
    @(negedge aclk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_wready", wready, 1'b1);
    check("post_rst_arready", arready, 1'b1);

    // Populate the address pool so every later read has defined contents
    for (int i = 0; i < 16; i++) begin
      do_write(32'(i) * 4, $urandom, 4'hF, 3'b000, 0, 0);
      wait_idle();
    end
    do_write(32'h0000_0FFC, $urandom, 4'hF, 3'b000, 0, 0);
    wait_idle();

    // Same-cycle AW/W, zero wait, then read back
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0);
    wait_idle();
    do_read(32'h10, 3'b000, 32'hDEAD_BEEF);
    wait_idle();

    // W three cycles ahead of AW with sparse strobes
    do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, 0);
    wait_idle();
    do_write(32'h20, 32'h1122_3344, 4'h5, 3'b000, 3, 0);
    wait_idle();
    do_read(32'h20, 3'b000, 32'hFF22_FF44);
    wait_idle();

    // Read wait states plus R backpressure
    read_wait_cycles = 4'd5;
    rready_force = 1'b0;
    @(negedge aclk); @(negedge aclk);
    do_read(32'h10, 3'b000, 32'hDEAD_BEEF);
    n = 0;
    while (!rvalid && n < BUDGET) begin
      check("arready_low_wait", arready, 1'b0);
      @(negedge aclk);
      n++;
    end
    check("rvalid_timeout", n >= BUDGET, 1'b0);
    repeat (4) begin
      check("arready_low_bp", arready, 1'b0);
      check("rvalid_bp", rvalid, 1'b1);
      @(negedge aclk);
    end
    rready_force = 1'b1;
    wait_idle();
    read_wait_cycles = '0;

    // Error responses
    old = model_read(32'h0);
    do_write(32'h0000_1000, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 0);
    wait_idle();
    do_read(32'h0, 3'b000, old);
    wait_idle();
    do_read(32'h10, 3'b010, model_read(32'h10));
    wait_idle();
    old = model_read(32'h14);
    do_write(32'h14, 32'h1234_5678, 4'hF, 3'b010, 0, 0);
    wait_idle();
    do_read(32'h14, 3'b000, old);
    wait_idle();
    do_read(32'h0000_2000, 3'b000, 32'h0);
    wait_idle();

    // Reset during W_WAIT discards the write; memory survives reset
    write_wait_cycles = 4'd8;
    fork
      send_aw(32'h3C, 3'b000, hs_a);
      send_w(32'hCAFE_F00D, 4'hF, hs_w);
    join
    repeat (3) begin
      @(negedge aclk);
      check("bvalid_in_wait", bvalid, 1'b0);
    end
    aresetn = 1'b0;
    #1;
    check("midrst_awready", awready, 1'b0);
    check("midrst_wready", wready, 1'b0);
    check("midrst_arready", arready, 1'b0);
    check("midrst_bvalid", bvalid, 1'b0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b1);
    check("rel_arready", arready, 1'b1);
    repeat (12) begin
      @(negedge aclk);
      check("bvalid_after_rst", bvalid, 1'b0);
    end
    write_wait_cycles = '0;
    do_read(32'h3C, 3'b000, model_read(32'h3C));
    wait_idle();

    // Read capture and memory write on the same edge
    old = model_read(32'h30);
    write_wait_cycles = 4'd3;
    read_wait_cycles  = 4'd3;
    fork
      do_write(32'h30, 32'h5A5A_1234, 4'hF, 3'b000, 0, 0);
      do_read(32'h30, 3'b000, old);
    join
    wait_idle();
    write_wait_cycles = '0;
    read_wait_cycles  = '0;
    do_read(32'h30, 3'b000, 32'h5A5A_1234);
    wait_idle();

    // Randomized traffic with backpressure and config changes in flight
    rand_bp     = 1'b1;
    cfg_shuffle = 1'b1;
    for (int i = 0; i < 80; i++) begin
      write_wait_cycles = 4'($urandom_range(0, 3));
      read_wait_cycles  = 4'($urandom_range(0, 3));
      a = pick_addr();
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, 3'($urandom_range(0, 7)), model_read(a));
      wait_idle();
    end
    rand_bp     = 1'b0;
    cfg_shuffle = 1'b0;
    wait_idle();

    check("b_queue_empty", q_b.size(), 0);
    check("r_queue_empty", q_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
